// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit processor control path.
// Holds the FSM state and opcode encodings, ALU select codes, field widths,
// the control-output bundle and the Moore output decode used by control_unit.
package cpu_pkg;

  localparam int unsigned PC_W    = 7;
  localparam int unsigned IR_W    = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned DADDR_W = 8;
  localparam int unsigned ALU_SW  = 3;

  localparam logic [ALU_SW-1:0] ALU_ZERO   = 3'b000;
  localparam logic [ALU_SW-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALU_SW-1:0] ALU_SUB    = 3'b010;
  localparam logic [ALU_SW-1:0] ALU_PASS_A = 3'b011;
  localparam logic [ALU_SW-1:0] ALU_XOR    = 3'b100;
  localparam logic [ALU_SW-1:0] ALU_OR     = 3'b101;
  localparam logic [ALU_SW-1:0] ALU_AND    = 3'b110;
  localparam logic [ALU_SW-1:0] ALU_INC    = 3'b111;

  // INIT must encode as zero: state_o reads 0 while reset is held.
  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OpNoop  = 4'd0,
    OpStore = 4'd1,
    OpLoad  = 4'd2,
    OpAdd   = 4'd3,
    OpSub   = 4'd4,
    OpHalt  = 4'd5
  } opcode_t;

  typedef struct packed {
    logic                i_rd;
    logic [DADDR_W-1:0]  d_addr;
    logic                d_wr;
    logic                rf_s;
    logic [REG_AW-1:0]   rf_w_addr;
    logic                rf_w_en;
    logic [REG_AW-1:0]   rf_ra_addr;
    logic [REG_AW-1:0]   rf_rb_addr;
    logic [ALU_SW-1:0]   alu_s;
    logic                halted;
  } ctrl_t;

  // Moore decode: every control output as a function of state and IR only.
  function automatic ctrl_t ctrl_decode(input state_t st, input logic [IR_W-1:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: c.i_rd = 1'b1;
      StLoadA: c.d_addr = ir[11:4];
      StLoadB: begin
        c.d_addr    = ir[11:4];
        c.rf_s      = 1'b1;
        c.rf_w_addr = ir[3:0];
        c.rf_w_en   = 1'b1;
      end
      StStore: begin
        c.d_addr     = ir[11:4];
        c.rf_ra_addr = ir[3:0];
        c.d_wr       = 1'b1;
      end
      StAdd, StSub: begin
        c.rf_ra_addr = ir[11:8];
        c.rf_rb_addr = ir[7:4];
        c.rf_w_addr  = ir[3:0];
        c.rf_w_en    = 1'b1;
        c.alu_s      = (st == StAdd) ? ALU_ADD : ALU_SUB;
      end
      StHalt:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/program_counter.sv
// 7-bit program counter.
// Ports: clk, reset_n (async active-low clear), clear (sync clear, used in INIT),
//        inc (advance by one, used in FETCH; wraps 127 -> 0), pc (current value).
module program_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else if (clear) begin
      pc_q <= '0;
    end else if (inc) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// Control unit for the 16-bit processor: owns PC and IR, fetches from a
// synchronous instruction ROM, decodes, and drives all datapath controls.
// Ports: clk, reset_n (async active-low); I_data/I_addr/I_rd (instruction ROM);
//        D_Addr/D_wr (data memory); RF_s, RF_W_addr, RF_W_en, RF_Ra_addr,
//        RF_Rb_addr (register file); Alu_s0 (ALU op); halted, state_o (status).
module control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IR_W-1:0]    I_data,
  output logic [PC_W-1:0]    I_addr,
  output logic               I_rd,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [REG_AW-1:0]  RF_W_addr,
  output logic               RF_W_en,
  output logic [REG_AW-1:0]  RF_Ra_addr,
  output logic [REG_AW-1:0]  RF_Rb_addr,
  output logic [ALU_SW-1:0]  Alu_s0,
  output logic               halted,
  output logic [3:0]         state_o
);

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [PC_W-1:0] pc;

  program_counter u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == StInit),
    .inc     (state_q == StFetch),
    .pc      (pc)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      StInit: begin
        state_d = StFetch;
        ir_d    = '0;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        // ROM data is valid this cycle; branch on it directly rather than on IR.
        ir_d = I_data;
        case (I_data[15:12])
          OpStore: state_d = StStore;
          OpLoad:  state_d = StLoadA;
          OpAdd:   state_d = StAdd;
          OpSub:   state_d = StSub;
          OpHalt:  state_d = StHalt;
          default: state_d = StNoop;
        endcase
      end
      StLoadA: state_d = StLoadB;
      StNoop, StLoadB, StStore, StAdd, StSub: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
    // Outputs are registered from the next state, so they stay Moore in
    // (state_q, ir_q) while reset can still clear them asynchronously.
    ctrl_d = ctrl_decode(state_d, ir_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      ir_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign I_addr     = pc;
  assign I_rd       = ctrl_q.i_rd;
  assign D_Addr     = ctrl_q.d_addr;
  assign D_wr       = ctrl_q.d_wr;
  assign RF_s       = ctrl_q.rf_s;
  assign RF_W_addr  = ctrl_q.rf_w_addr;
  assign RF_W_en    = ctrl_q.rf_w_en;
  assign RF_Ra_addr = ctrl_q.rf_ra_addr;
  assign RF_Rb_addr = ctrl_q.rf_rb_addr;
  assign Alu_s0     = ctrl_q.alu_s;
  assign halted     = ctrl_q.halted;
  assign state_o    = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a ROM model, a write-event scoreboard
// drained by a negedge monitor, and directed sequencing/reset checks.
module tb_control_unit;

  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_NOOP   = 4'd3;
  localparam logic [3:0] ST_LOADA  = 4'd4;
  localparam logic [3:0] ST_LOADB  = 4'd5;
  localparam logic [3:0] ST_STORE  = 4'd6;
  localparam logic [3:0] ST_ADD    = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd9;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] I_data  = 16'h0000;
  logic [6:0]  I_addr;
  logic        I_rd;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic        halted;
  logic [3:0]  state_o;

  logic [15:0] rom [128];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] i_addr;
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got, mon_exp;

  control_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .I_data     (I_data),
    .I_addr     (I_addr),
    .I_rd       (I_rd),
    .D_Addr     (D_Addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .Alu_s0     (Alu_s0),
    .halted     (halted),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for the address presented in FETCH appears next cycle.
  always @(posedge clk) if (I_rd) I_data <= rom[I_addr];

  function automatic ev_t mk_ev(input logic [6:0] ia, input logic [7:0] da, input logic wr,
                                input logic s, input logic [3:0] wa, input logic wen,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [2:0] alu);
    ev_t e;
    e = '{i_addr: ia, d_addr: da, d_wr: wr, rf_s: s, w_addr: wa, w_en: wen,
          ra: ra, rb: rb, alu: alu};
    return e;
  endfunction

  // Every write cycle must match the next expected event, in order.
  always @(negedge clk) begin
    if (reset_n && (RF_W_en || D_wr)) begin
      mon_got = '{i_addr: I_addr, d_addr: D_Addr, d_wr: D_wr, rf_s: RF_s, w_addr: RF_W_addr,
                  w_en: RF_W_en, ra: RF_Ra_addr, rb: RF_Rb_addr, alu: Alu_s0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL write_event got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic step_check(input logic [3:0] st, input logic [6:0] ia, input logic rd,
                            input string name);
    @(posedge clk);
    #1;
    checks++;
    if (state_o !== st || I_addr !== ia || I_rd !== rd) begin
      errors++;
      $display("FAIL %s got state=%0d I_addr=%0d I_rd=%b required state=%0d I_addr=%0d I_rd=%b",
               name, state_o, I_addr, I_rd, st, ia, rd);
    end
  endtask

  int halt_bad;
  int wrap_n;
  logic [6:0] last_fetch;

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3125;  // ADD R5 = R1 + R2
    rom[1] = 16'h2103;  // LOAD R3 = mem[0x10]
    rom[2] = 16'h1207;  // STORE mem[0x20] = R7
    rom[3] = 16'hF000;  // unused opcode
    rom[4] = 16'h5000;  // HALT
    exp_q.push_back(mk_ev(7'd1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b1, 4'd1, 4'd2, 3'b001));
    exp_q.push_back(mk_ev(7'd2, 8'h10, 1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 4'd0, 3'b000));
    exp_q.push_back(mk_ev(7'd3, 8'h20, 1'b1, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, 3'b000));

    reset_n = 1'b0;
    #1;
    check1("reset_outputs", {I_addr, I_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                             RF_Ra_addr, RF_Rb_addr, Alu_s0, halted, state_o}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Program A: ADD, LOAD, STORE, unused opcode, HALT.
    step_check(ST_FETCH, 7'd0, 1'b1, "first_fetch");
    step_check(ST_DECODE, 7'd1, 1'b0, "decode_add");
    step_check(ST_ADD, 7'd1, 1'b0, "exec_add");
    step_check(ST_FETCH, 7'd1, 1'b1, "fetch_after_add");
    check1("add_wen_one_cycle", RF_W_en, 0);
    step_check(ST_DECODE, 7'd2, 1'b0, "decode_load");
    step_check(ST_LOADA, 7'd2, 1'b0, "load_a");
    check1("load_a_outputs", {D_Addr, RF_s, RF_W_en, D_wr}, {8'h10, 3'b000});
    step_check(ST_LOADB, 7'd2, 1'b0, "load_b");
    step_check(ST_FETCH, 7'd2, 1'b1, "fetch_after_load");
    step_check(ST_DECODE, 7'd3, 1'b0, "decode_store");
    step_check(ST_STORE, 7'd3, 1'b0, "exec_store");
    step_check(ST_FETCH, 7'd3, 1'b1, "fetch_after_store");
    check1("store_wr_one_cycle", D_wr, 0);
    step_check(ST_DECODE, 7'd4, 1'b0, "decode_unused");
    step_check(ST_NOOP, 7'd4, 1'b0, "unused_as_noop");
    check1("noop_no_enables", {D_wr, RF_W_en, RF_s, Alu_s0, D_Addr, halted}, 0);
    step_check(ST_FETCH, 7'd4, 1'b1, "fetch_halt");
    step_check(ST_DECODE, 7'd5, 1'b0, "decode_halt");
    step_check(ST_HALT, 7'd5, 1'b0, "enter_halt");
    check1("halted_flag", halted, 1);
    halt_bad = 0;
    repeat (22) begin
      @(posedge clk);
      #1;
      if (state_o !== ST_HALT || I_addr !== 7'd5 || I_rd !== 1'b0 || halted !== 1'b1)
        halt_bad++;
    end
    check1("halt_hold", halt_bad, 0);
    check1("queue_drained_a", exp_q.size(), 0);

    // Program B: ADD at 0 followed by 127 NOOPs; PC must wrap and re-run ADD.
    @(negedge clk) reset_n = 1'b0;
    #1;
    check1("reset_from_halt", {halted, state_o, I_addr}, 0);
    for (int i = 1; i < 128; i++) rom[i] = 16'h0000;
    exp_q.push_back(mk_ev(7'd1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b1, 4'd1, 4'd2, 3'b001));
    exp_q.push_back(mk_ev(7'd1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b1, 4'd1, 4'd2, 3'b001));
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    wrap_n = 0;
    last_fetch = 7'd0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (state_o == ST_FETCH) begin
        if (I_addr == 7'd0 && n > 1) begin
          wrap_n = n;
          break;
        end
        last_fetch = I_addr;
      end
    end
    // FETCH of address k lands on cycle 1 + 3k, so the wrapped fetch is cycle 385.
    check1("wrap_cycle", wrap_n, 385);
    check1("last_fetch_before_wrap", last_fetch, 127);
    step_check(ST_DECODE, 7'd1, 1'b0, "decode_after_wrap");
    step_check(ST_ADD, 7'd1, 1'b0, "add_after_wrap");
    @(negedge clk);
    #1;
    check1("queue_drained_b", exp_q.size(), 0);

    // Reset asserted during ADD execute must drop the write enable at once.
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step_check(ST_FETCH, 7'd0, 1'b1, "fetch_c");
    step_check(ST_DECODE, 7'd1, 1'b0, "decode_c");
    step_check(ST_ADD, 7'd1, 1'b0, "exec_c");
    check1("mid_add_wen_high", RF_W_en, 1);
    reset_n = 1'b0;
    #1;
    check1("async_reset_wen", RF_W_en, 0);
    check1("async_reset_state", state_o, ST_INIT);
    check1("async_reset_addr", I_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    check1("queue_drained_c", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
